instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Upstream neighbour of the CPU controller: owns the PC and IR of the 19-bit CPU.
//  Fetches the instruction at PC from instruction memory over a req/ack handshake.
//  Presents opcode IR[18:15] to the controller and executes its loadIR/loadPC/incPC/selA commands.
//  Raises stall while a fetch is outstanding; flags a sticky fault when memory never answers.
// PARAMETERS
//  ADDR_W    15  PC / imem address width; the jump target is IR[ADDR_W-1:0]
//  RESET_PC  0   PC value after reset
//  TIMEOUT   16  max cycles in REQ without imem_ack before fault (>=2)
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst_n      in   1       asynchronous active-low reset
//  en         in   1       CPU enable; 0 = abort and idle
//  loadIR     in   1       controller: start fetch of instruction at PC
//  loadPC     in   1       controller: load PC (qualified by selA)
//  incPC      in   1       controller: PC <= PC+1
//  selA       in   1       controller: 1 = PC source is the IR address field (JMP)
//  imem_req   out  1       fetch request, held until ack
//  imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
//  imem_ack   in   1       memory ack; imem_rdata valid in the same cycle
//  imem_rdata in   19      instruction word
//  ir         out  19      instruction register
//  opcode     out  4       ir[18:15], to the controller
//  pc         out  ADDR_W  program counter
//  ir_valid   out  1       1-cycle pulse when ir has been updated
//  stall      out  1       1 while a fetch is outstanding (state REQ)
//  fault      out  1       sticky imem timeout flag
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, ir=0, imem_addr=0, imem_req=0, ir_valid=0, stall=0,
//   fault=0, timeout counter=0, state=IDLE.
//  FSM (3 states):
//   IDLE: if en & loadIR & !fault: imem_addr<=pc, imem_req<=1, cnt<=0, go to REQ.
//   REQ: stall=1, imem_req=1, imem_addr held.
//    imem_ack: ir<=imem_rdata, ir_valid=1 next cycle, imem_req<=0, go to IDLE.
//    No ack: cnt++. When cnt reaches TIMEOUT-1 without ack: fault<=1, imem_req<=0, go to FAULT.
//    en=0 (takes priority over ack): abort, imem_req<=0, ir unchanged, go to IDLE.
//   FAULT: imem_req=0, stall=0, all commands ignored; only rst_n exits.
//  Fetch latency: ir_valid is asserted one cycle after the ack cycle. Minimum loadIR-to-ir_valid = 2 cycles (ack in the first REQ cycle).
//  PC update: applied only in IDLE with en=1 and not in FAULT. Priority, highest first:
//   - loadPC & selA: pc<=ir[ADDR_W-1:0]
//   - incPC: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0
//   - loadPC & !selA: no PC change (the controller issues this in its load state)
//  Simultaneous loadIR and a PC update in IDLE: the fetch uses the old pc; the update lands for the next fetch.
//  PC commands received in REQ are dropped, and the in-flight imem_addr is never disturbed.
//  loadIR received while in REQ is ignored; there are no queued fetches.
//  An imem_ack arriving in IDLE or FAULT (late ack after an abort) is ignored, and ir is unchanged.
//  opcode is combinational from ir. All other outputs are registered, except stall (decoded from state).
// STRUCTURE
//  cpu19_pkg: INSTR_W=19, OPCODE_W=4, OPC_MSB=18, OPC_LSB=15, OP_JMP=4'b0111, fetch state enum.
//  Sub-module fetch_pc: PC register holding the priority mux (jump/inc/hold), the wrap, and the reset value.
//  The FSM, the timeout counter and the IR register stay in instr_fetch.
// TESTING
//  1. Reset then en=1, loadIR, ack 1 cycle later with rdata=19'h4_0005
//     -> imem_addr=0, stall high 2 cycles, ir=19'h40005, opcode=4'b1000, ir_valid single pulse.
//  2. Wrap: ADDR_W=15, pc=15'h7FFF, incPC -> pc=0.
//     loadPC=1, selA=0 -> pc unchanged.
//  3. Jump: ir=19'h3_8123, loadPC & selA & incPC in the same cycle -> pc=15'h0123 (jump wins).
//  4. en dropped in cycle 2 of REQ, ack arrives 1 cycle later -> imem_req=0, ir unchanged, no ir_valid, state IDLE.
//  5. No ack for TIMEOUT=16 cycles -> fault=1, imem_req=0.
//     A following loadIR issues no request; rst_n clears fault.
//  6. In REQ, pulse incPC and loadIR -> pc unchanged, imem_addr stable, exactly one fetch completes.

Source files
------------

// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU: instruction field layout, opcodes and fetch FSM states.
package cpu19_pkg;

   localparam int unsigned INSTR_W  = 19;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned OPC_MSB  = 18;
   localparam int unsigned OPC_LSB  = 15;

   localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: jump/increment/hold priority mux with natural wrap, updated only when enabled.
module fetch_pc #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_en_i,
   input  logic              load_pc_i,
   input  logic              inc_pc_i,
   input  logic              sel_a_i,
   input  logic [ADDR_W-1:0] jmp_addr_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Jump beats increment; loadPC without selA leaves the PC alone.
   always_comb begin
      pc_d = pc_q;
      if (upd_en_i) begin
         if (load_pc_i && sel_a_i) begin
            pc_d = jmp_addr_i;
         end else if (inc_pc_i) begin
            pc_d = pc_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= ADDR_W'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC and IR, fetches over an imem req/ack handshake,
// stalls the controller while a fetch is outstanding and latches a sticky timeout fault.
module instr_fetch
   import cpu19_pkg::*;
#(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                loadIR,
   input  logic                loadPC,
   input  logic                incPC,
   input  logic                selA,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  ir,
   output logic [OPCODE_W-1:0] opcode,
   output logic [ADDR_W-1:0]   pc,
   output logic                ir_valid,
   output logic                stall,
   output logic                fault
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   fetch_state_e         state_q, state_d;
   logic                 req_q, req_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 ir_valid_q, ir_valid_d;
   logic                 fault_q, fault_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pc_upd_en;

   assign pc_upd_en = (state_q == S_IDLE) && en;

   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_en_i   (pc_upd_en),
      .load_pc_i  (loadPC),
      .inc_pc_i   (incPC),
      .sel_a_i    (selA),
      .jmp_addr_i (ir_q[ADDR_W-1:0]),
      .pc_o       (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         fault_q    <= fault_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next state: abort on en=0 outranks ack, ack outranks timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (en && loadIR && !fault_q) state_d = S_REQ;
         end
         S_REQ: begin
            if (!en || imem_ack)          state_d = S_IDLE;
            else if (cnt_q == CNT_MAX)    state_d = S_FAULT;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_d      = req_q;
      addr_d     = addr_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      fault_d    = fault_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (en && loadIR && !fault_q) begin
               addr_d = pc;
               req_d  = 1'b1;
               cnt_d  = '0;
            end
         end
         S_REQ: begin
            if (!en) begin
               req_d = 1'b0;
            end else if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               req_d      = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               fault_d = 1'b1;
               req_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FAULT: req_d = 1'b0;
         default: req_d = 1'b0;
      endcase
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign fault     = fault_q;
   assign opcode    = get_opcode(ir_q);
   assign stall     = (state_q == S_REQ);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch latency, PC priority/wrap, abort, timeout fault, REQ-time commands.
module tb_instr_fetch;
   import cpu19_pkg::*;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned TIMEOUT = 16;

   logic                clk;
   logic                rst_n;
   logic                en, loadIR, loadPC, incPC, selA;
   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [INSTR_W-1:0]  imem_rdata;
   logic [INSTR_W-1:0]  ir;
   logic [OPCODE_W-1:0] opcode;
   logic [ADDR_W-1:0]   pc;
   logic                ir_valid;
   logic                stall;
   logic                fault;

   int checks = 0;
   int errors = 0;

   instr_fetch #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (0),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .loadIR     (loadIR),
      .loadPC     (loadPC),
      .incPC      (incPC),
      .selA       (selA),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .opcode     (opcode),
      .pc         (pc),
      .ir_valid   (ir_valid),
      .stall      (stall),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete fetch: loadIR for one cycle, then ack with rdata after 'waits' silent REQ cycles.
   task automatic fetch(input logic [INSTR_W-1:0] rdata, input int waits);
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      for (int i = 0; i < waits; i++) tick();
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = '0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; loadIR = 1'b0; loadPC = 1'b0; incPC = 1'b0; selA = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0;
      tick(); tick();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_irv", 32'(ir_valid), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      rst_n = 1'b1;
      en    = 1'b1;
      tick();

      // 1: basic fetch with ack in the second REQ cycle
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      chk("t1_stall_c1", 32'(stall), 32'h1);
      chk("t1_req_c1", 32'(imem_req), 32'h1);
      chk("t1_addr", 32'(imem_addr), 32'h0);
      tick();
      chk("t1_stall_c2", 32'(stall), 32'h1);
      chk("t1_irv_early", 32'(ir_valid), 32'h0);
      imem_ack = 1'b1; imem_rdata = 19'h4_0005;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
      chk("t1_stall_done", 32'(stall), 32'h0);
      chk("t1_req_done", 32'(imem_req), 32'h0);
      chk("t1_ir", 32'(ir), 32'h4_0005);
      chk("t1_opcode", 32'(opcode), 32'h8);
      chk("t1_irv", 32'(ir_valid), 32'h1);
      tick();
      chk("t1_irv_pulse", 32'(ir_valid), 32'h0);

      // 2: jump to 0x7FFF, then wrap on increment, then loadPC without selA holds
      fetch(19'h0_7FFF, 0);
      loadPC = 1'b1; selA = 1'b1;
      tick();
      loadPC = 1'b0; selA = 1'b0;
      chk("t2_jmp_7fff", 32'(pc), 32'h7FFF);
      incPC = 1'b1;
      tick();
      chk("t2_wrap", 32'(pc), 32'h0);
      tick();
      incPC = 1'b0;
      chk("t2_inc", 32'(pc), 32'h1);
      loadPC = 1'b1;
      tick();
      loadPC = 1'b0;
      chk("t2_hold", 32'(pc), 32'h1);

      // 3: jump beats increment
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      chk("t3_addr", 32'(imem_addr), 32'h1);
      imem_ack = 1'b1; imem_rdata = 19'h3_8123;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
      chk("t3_opcode", 32'(opcode), 32'(OP_JMP));
      loadPC = 1'b1; selA = 1'b1; incPC = 1'b1;
      tick();
      loadPC = 1'b0; selA = 1'b0; incPC = 1'b0;
      chk("t3_pc", 32'(pc), 32'h0123);

      // 4: abort in REQ cycle 2, late ack afterwards is ignored
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      chk("t4_addr", 32'(imem_addr), 32'h0123);
      tick();
      en = 1'b0;
      imem_ack = 1'b1; imem_rdata = 19'h7_FFFF;
      tick();
      chk("t4_req_abort", 32'(imem_req), 32'h0);
      chk("t4_stall_abort", 32'(stall), 32'h0);
      chk("t4_ir_abort", 32'(ir), 32'h3_8123);
      chk("t4_irv_abort", 32'(ir_valid), 32'h0);
      en = 1'b1;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
      chk("t4_ir_late", 32'(ir), 32'h3_8123);
      chk("t4_irv_late", 32'(ir_valid), 32'h0);
      chk("t4_stall_late", 32'(stall), 32'h0);

      // 6: commands during REQ are dropped; one fetch only
      loadIR = 1'b1;
      tick();
      incPC = 1'b1;
      tick();
      loadIR = 1'b0; incPC = 1'b0;
      chk("t6_pc", 32'(pc), 32'h0123);
      chk("t6_addr", 32'(imem_addr), 32'h0123);
      chk("t6_stall", 32'(stall), 32'h1);
      imem_ack = 1'b1; imem_rdata = 19'h1_0042;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
      chk("t6_ir", 32'(ir), 32'h1_0042);
      chk("t6_irv", 32'(ir_valid), 32'h1);
      tick();
      chk("t6_irv_pulse", 32'(ir_valid), 32'h0);
      chk("t6_no_refetch", 32'(imem_req), 32'h0);
      chk("t6_pc_after", 32'(pc), 32'h0123);

      // loadIR with incPC in IDLE: fetch uses the old pc
      loadIR = 1'b1; incPC = 1'b1;
      tick();
      loadIR = 1'b0; incPC = 1'b0;
      chk("tx_addr_old", 32'(imem_addr), 32'h0123);
      chk("tx_pc_new", 32'(pc), 32'h0124);
      imem_ack = 1'b1; imem_rdata = 19'h0_0001;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;

      // 5: timeout after TIMEOUT silent REQ cycles
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      for (int i = 1; i < int'(TIMEOUT); i++) tick();
      chk("t5_req_pre", 32'(imem_req), 32'h1);
      chk("t5_fault_pre", 32'(fault), 32'h0);
      tick();
      chk("t5_fault", 32'(fault), 32'h1);
      chk("t5_req", 32'(imem_req), 32'h0);
      chk("t5_stall", 32'(stall), 32'h0);
      loadIR = 1'b1; incPC = 1'b1;
      tick(); tick();
      loadIR = 1'b0; incPC = 1'b0;
      chk("t5_no_req", 32'(imem_req), 32'h0);
      chk("t5_pc_frozen", 32'(pc), 32'h0124);
      chk("t5_sticky", 32'(fault), 32'h1);
      rst_n = 1'b0;
      #2;
      chk("t5_rst_fault", 32'(fault), 32'h0);
      chk("t5_rst_pc", 32'(pc), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
